// File: rtl/ps2_paddle_rx.sv
// ps2_paddle_rx: receive-only PS/2 keyboard deframer with held paddle/launch key flags
module ps2_paddle_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       key_left,
  output logic       key_right,
  output logic       key_launch
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] F_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic clk_s1, clk_s2, dat_s1, dat_s2, filt, filt_q, fall;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic par, sv_n, pe_n, fe_n, ext, brk;
  assign fall = filt_q & ~filt;
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      {clk_s2, clk_s1, dat_s2, dat_s1} <= '1;
      filt   <= 1'b1;
      filt_q <= 1'b1;
      fcnt   <= '0;
    end else begin
      {clk_s2, clk_s1} <= {clk_s1, PS2_CLK};
      {dat_s2, dat_s1} <= {dat_s1, PS2_DAT};
      filt_q <= filt;
      fcnt   <= (clk_s2 == filt || fcnt == F_MAX) ? '0 : fcnt + 1'b1;
      filt   <= (clk_s2 != filt && fcnt == F_MAX) ? clk_s2 : filt;
    end
  // A fall always takes priority over an expiring timeout.
  always_comb begin
    state_n = state;
    sv_n = 1'b0;
    pe_n = 1'b0;
    fe_n = 1'b0;
    if (fall)
      case (state)
        IDLE:    state_n = dat_s2 ? IDLE : DATA;
        DATA:    state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_n = STOP;
        default: begin
          state_n = IDLE;
          fe_n = ~dat_s2;
          sv_n = dat_s2 & (^{shreg, par});
          pe_n = dat_s2 & ~(^{shreg, par});
        end
      endcase
    else if (state != IDLE && tcnt == T_MAX) begin
      state_n = IDLE;
      fe_n = 1'b1;
    end
  end
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      state      <= IDLE;
      tcnt       <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      tcnt       <= (state == IDLE || fall || state_n == IDLE) ? '0 : tcnt + 1'b1;
      bit_cnt    <= (fall && state == DATA) ? bit_cnt + 1'b1 : (state == IDLE ? '0 : bit_cnt);
      shreg      <= (fall && state == DATA) ? {dat_s2, shreg[7:1]} : shreg;
      par        <= (fall && state == PARITY) ? dat_s2 : par;
      scan_code  <= sv_n ? shreg : scan_code;
      scan_valid <= sv_n;
      parity_err <= pe_n;
      frame_err  <= fe_n;
    end
  // Prefix decoder: E0 marks extended, F0 marks break; errors drop a partial sequence.
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_launch <= 1'b0;
    end else if (parity_err || frame_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (scan_valid) begin
      ext        <= (scan_code == 8'hE0) || (ext && scan_code == 8'hF0);
      brk        <= (scan_code == 8'hF0) || (brk && scan_code == 8'hE0);
      key_left   <= (ext && scan_code == 8'h6B) ? ~brk : key_left;
      key_right  <= (ext && scan_code == 8'h74) ? ~brk : key_right;
      key_launch <= (!ext && scan_code == 8'h29) ? ~brk : key_launch;
    end
endmodule

// File: tb/tb_ps2_paddle_rx.sv
// tb_ps2_paddle_rx: randomized and directed PS/2 frames against a key-sequence reference model
module tb_ps2_paddle_rx;
  localparam int FL = 8;
  localparam int TO = 400;
  localparam int H  = 25;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic [7:0] scan_code;
  logic scan_valid, parity_err, frame_err, key_left, key_right, key_launch;
  int cyc = 0, checks = 0, errors = 0;
  int sv_cnt = 0, pe_cnt = 0, fe_cnt = 0, ev_cyc = 0, t_fall = 0;
  logic [7:0] m_code = 8'h00;
  bit m_ext, m_brk, m_left, m_right, m_launch;

  ps2_paddle_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .scan_code(scan_code), .scan_valid(scan_valid), .parity_err(parity_err),
    .frame_err(frame_err), .key_left(key_left), .key_right(key_right), .key_launch(key_launch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (scan_valid) begin sv_cnt++; ev_cyc = cyc; end
    if (parity_err) begin pe_cnt++; ev_cyc = cyc; end
    if (frame_err) begin fe_cnt++; ev_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      tick(4); ps2_clk = 1'b0; tick(FL - 1); ps2_clk = 1'b1; tick(H - 4 - (FL - 1));
    end else tick(H);
    ps2_clk = 1'b0;
    t_fall = cyc;
    tick(H);
    ps2_clk = 1'b1;
  endtask

  task automatic check_keys(input string tag);
    check({tag, "_keys"}, {29'd0, key_left, key_right, key_launch}, {29'd0, m_left, m_right, m_launch});
    check({tag, "_code"}, {24'd0, scan_code}, {24'd0, m_code});
  endtask

  task automatic frame(input logic [7:0] code, input bit bad_par, input bit bad_stop, input int glitch_bit);
    logic [10:0] f;
    f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    sv_cnt = 0; pe_cnt = 0; fe_cnt = 0; ev_cyc = -1;
    for (int i = 0; i < 11; i++) ps2_bit(f[i], i == glitch_bit);
    tick(20);
    check("sv_cnt", sv_cnt, (!bad_par && !bad_stop) ? 1 : 0);
    check("pe_cnt", pe_cnt, (bad_par && !bad_stop) ? 1 : 0);
    check("fe_cnt", fe_cnt, bad_stop ? 1 : 0);
    check("latency", ev_cyc - t_fall, 3 + FL);
    if (bad_par || bad_stop) begin
      m_ext = 0; m_brk = 0;
    end else begin
      m_code = code;
      if (code == 8'hE0) m_ext = 1;
      else if (code == 8'hF0) m_brk = 1;
      else begin
        if (m_ext && code == 8'h6B) m_left = !m_brk;
        if (m_ext && code == 8'h74) m_right = !m_brk;
        if (!m_ext && code == 8'h29) m_launch = !m_brk;
        m_ext = 0; m_brk = 0;
      end
    end
    check_keys($sformatf("frame_%02h", code));
  endtask

  task automatic send(input logic [7:0] code);
    frame(code, 1'b0, 1'b0, -1);
  endtask

  task automatic stall(input logic [7:0] code);
    fe_cnt = 0; sv_cnt = 0; ev_cyc = -1;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(code[i], 1'b0);
    tick(TO + 40);
    check("to_fe_cnt", fe_cnt, 1);
    check("to_sv_cnt", sv_cnt, 0);
    check("to_latency", ev_cyc - t_fall, 3 + FL + TO);
    m_ext = 0; m_brk = 0;
  endtask

  initial begin
    logic [7:0] pool [6];
    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h29, 8'h1C};
    m_ext = 0; m_brk = 0; m_left = 0; m_right = 0; m_launch = 0;
    tick(5);
    check("rst_out", {21'd0, scan_code, scan_valid, parity_err, frame_err, key_left, key_right, key_launch}, 0);
    rst_n = 1'b1;
    tick(20);
    send(8'h29);
    send(8'hF0); send(8'h29);
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'h6B);
    frame(8'h74, 1'b1, 1'b0, -1);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hE0); frame(8'h29, 1'b1, 1'b0, -1); send(8'h74);
    send(8'h29);
    frame(8'h29, 1'b0, 1'b1, -1);
    stall(8'h29);
    send(8'h29);
    ps2_clk = 1'b0; tick(FL - 1); ps2_clk = 1'b1; tick(20);
    send(8'hF0);
    frame(8'h29, 1'b0, 1'b0, 5);
    send(8'hE0); send(8'h74);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    tick(10);
    rst_n = 1'b0;
    #1;
    check("rst_mid", {21'd0, scan_code, scan_valid, parity_err, frame_err, key_left, key_right, key_launch}, 0);
    m_code = 0; m_ext = 0; m_brk = 0; m_left = 0; m_right = 0; m_launch = 0;
    tick(5); rst_n = 1'b1; tick(20);
    send(8'hE0); send(8'h74);
    for (int n = 0; n < 30; n++)
      frame(pool[$urandom_range(5)], $urandom_range(7) == 0, $urandom_range(9) == 0,
            $urandom_range(3) == 0 ? int'($urandom_range(10)) : -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule

// File: doc/ps2_paddle_rx.md
Name: ps2_paddle_rx

Overview:
- Host-side PS/2 keyboard receiver for the Breakout player input path.
- Samples the open-collector PS2_CLK/PS2_DAT lines, deframes 11-bit device-to-host frames and reports each scan code.
- Decodes make/break/extended prefixes into held flags for paddle left, paddle right and ball launch, which the game controller consumes alongside KEY/SW.
- Receive-only: never drives the PS/2 lines.

Parameters:
- FILTER_LEN, 8: consecutive CLOCK_50 cycles a synchronised PS2_CLK level must persist before the filtered clock takes it (≥2).
- TIMEOUT_CYCLES, 100000: CLOCK_50 cycles (2 ms) allowed between filtered falling edges inside a frame.

Ports:
- CLOCK_50 input 1: system clock, 50 MHz.
- RESET_N input 1: reset, asynchronous, active-low.
- PS2_CLK input 1: raw PS/2 clock from the device.
- PS2_DAT input 1: raw PS/2 data from the device.
- scan_code output 8: last correctly received byte.
- scan_valid output 1: one-cycle pulse when scan_code updates.
- parity_err output 1: one-cycle pulse when a frame fails odd parity.
- frame_err output 1: one-cycle pulse on bad stop bit or mid-frame timeout.
- key_left output 1: E0 6B (cursor left) held.
- key_right output 1: E0 74 (cursor right) held.
- key_launch output 1: 29 (space) held.

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE.
  - Both 2-FF synchronisers, the filtered clock and its previous-value register reset to 1 (bus idle high).
  - Filter counter, timeout counter and decoder prefix flags cleared.
- Filter:
  - Counter increments while the synchronised PS2_CLK differs from the filtered value; it clears on agreement.
  - On the FILTER_LEN-th consecutive differing cycle the filtered value flips.
  - fall = previous filtered 1 and filtered 0.
  - PS2_DAT is only synchronised and is sampled in the fall cycle.
- FSM states IDLE, DATA, PARITY, STOP; all transitions occur only on fall, except timeout.
  - IDLE: dat=0 → DATA, bit_cnt=0. dat=1 → stay in IDLE (spurious edge ignored, no error).
  - DATA: shift dat in LSB-first (shift right, dat into bit 7); after the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP, dat=1 and the XOR of the 8 data bits and parity = 1: load scan_code, pulse scan_valid → IDLE.
  - STOP, dat=1 and parity fails: pulse parity_err; scan_code unchanged → IDLE.
  - STOP, dat=0: pulse frame_err; parity is not checked → IDLE.
- Timeout:
  - Counter clears on every fall and in IDLE.
  - In any state other than IDLE, reaching TIMEOUT_CYCLES pulses frame_err and returns to IDLE.
- Latency: pulses are registered. scan_valid/parity_err/frame_err assert exactly 2+FILTER_LEN+1 CLOCK_50 cycles after the raw PS2_CLK stop-bit falling edge (data stable).
- Decoder, acting on scan_valid:
  - E0 sets ext.
  - F0 sets brk; ext is kept.
  - Any other code: if (ext, code) matches a key, set its flag to !brk. Then clear ext and brk.
  - Non-extended 6B/74 and extended 29 match nothing.
  - E1 and all other codes are treated as non-matching.
  - Typematic repeat makes leave a held flag at 1.
  - Flags update in the cycle after scan_valid.
- Errors: parity_err or frame_err clears ext and brk (partial sequence discarded); held flags are unchanged.
- Reset mid-frame: immediate return to reset state; the next complete frame decodes normally.
- Simultaneous: timeout and fall in the same cycle → fall wins (counter clears, edge processed).

Test Plan:
- Frame 0x29 (parity 0, stop 1), 12.5 kHz PS2_CLK: scan_valid one cycle, scan_code=0x29, key_launch=1. Then F0, 29: key_launch=0, scan_code=0x29.
- E0 6B: key_left=1. E0 74: key_right=1, both high. E0 F0 6B: key_left=0, key_right=1. Plain 6B: key_left stays 0.
- Frame 0x74 with parity 0 (bad): parity_err one cycle at 2+FILTER_LEN+1 cycles after the stop fall; no scan_valid; scan_code keeps its prior value. After E0 then a bad frame, a following 74 does not set key_right.
- Frame 0x29 with stop bit 0: frame_err pulse, no scan_valid, key_launch unchanged.
- Stall after 4 data bits for TIMEOUT_CYCLES: frame_err pulse exactly at timeout, FSM in IDLE. A following valid 0x29 yields scan_valid, scan_code=0x29.
- PS2_CLK low glitch of FILTER_LEN-1 cycles in IDLE and mid-frame: no bit consumed, the frame still decodes correctly. RESET_N low during bit 5: all outputs 0 at once, and a following E0 74 sets key_right=1.
